avr_irq_ctrl: RTL and testbench

- Interrupt controller directly downstream of avr_systick and the other peripheral irq outputs; consumes their irq lines and feeds the AVR core's single interrupt request.
- Per-source pending latch, mask, edge/level select, fixed priority, and a req/ack/ret handshake with the core.
- CPU-visible through the same 2-bit I/O register port style as the other avr_* peripherals.

---
 rtl/avr_irq_ctrl_pkg.sv | 23 ++
 rtl/avr_irq_prio_enc.sv | 24 ++
 rtl/avr_irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_avr_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_irq_ctrl_pkg.sv
// Shared definitions for the AVR interrupt controller: register map,
// ICTRL bit positions and handshake FSM state encoding.
package avr_irq_ctrl_pkg;

    // I/O register addresses
    localparam logic [1:0] A_IPEND = 2'd0;
    localparam logic [1:0] A_IMASK = 2'd1;
    localparam logic [1:0] A_IEDGE = 2'd2;
    localparam logic [1:0] A_ICTRL = 2'd3;

    // ICTRL bit positions
    localparam int unsigned BIT_GIE = 7;
    localparam int unsigned BIT_REQ = 6;
    localparam int unsigned BIT_SVC = 5;

    // Core handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/avr_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req.
// Ports: req (N_IRQ lines in), valid_c (any bit set), index_c (winner).
module avr_irq_prio_enc #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned VEC_W = 3
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid_c,
    output logic [VEC_W-1:0] index_c
);

    // Scan from the top down so the lowest set index is written last
    always_comb begin
        valid_c = 1'b0;
        index_c = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                index_c = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/avr_irq_ctrl.sv
// AVR interrupt controller: per-source pending latch, mask, edge/level
// select, fixed priority (source 0 highest) and req/ack/ret handshake
// with the core. Optional macro AVR_IRQ_SYNC_EN adds a 2-flop
// synchroniser on every irq_src bit.
// Ports: clk, rst (async active-low); io_re/io_we/io_a/io_di/io_do I/O
// register port; irq_src peripheral lines; irq_req/irq_vec to the core;
// irq_ack/irq_ret pulses from the core.
module avr_irq_ctrl
    import avr_irq_ctrl_pkg::*;
#(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned VEC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_re,
    input  logic             io_we,
    input  logic [1:0]       io_a,
    input  logic [7:0]       io_di,
    output logic [7:0]       io_do,
    input  logic [N_IRQ-1:0] irq_src,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             irq_ret
);

    logic [N_IRQ-1:0] src_in;
    logic [N_IRQ-1:0] src_prev;
    logic [N_IRQ-1:0] ipend;
    logic [N_IRQ-1:0] ipend_nx;
    logic [N_IRQ-1:0] imask;
    logic [N_IRQ-1:0] iedge;
    logic             gie;
    state_t           state;
    state_t           state_nx;
    logic [VEC_W-1:0] vec_nx;
    logic             win_valid;
    logic [VEC_W-1:0] win_idx;
    logic             ack_take;
    logic [7:0]       ctrl_rd;

`ifdef AVR_IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync_q1;
    logic [N_IRQ-1:0] sync_q2;

    // Two-flop synchroniser for asynchronous peripheral lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end
    assign src_in = sync_q2;
`else
    assign src_in = irq_src;
`endif

    assign ack_take = irq_ack && (state == ST_REQ);

    // Pending update: edge sources latch rises (set beats clear),
    // level sources simply follow the line
    always_comb begin
        ipend_nx = ipend;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (iedge[i]) begin
                ipend_nx[i] = (src_in[i] & ~src_prev[i]) |
                              (ipend[i] & ~((io_we && io_a == A_IPEND && io_di[i]) ||
                                            (ack_take && irq_vec == VEC_W'(i))));
            end else begin
                ipend_nx[i] = src_in[i];
            end
        end
    end

    avr_irq_prio_enc #(
        .N_IRQ (N_IRQ),
        .VEC_W (VEC_W)
    ) u_prio (
        .req     (ipend & imask),
        .valid_c (win_valid),
        .index_c (win_idx)
    );

    // Handshake next-state; vector only changes on IDLE->REQ
    always_comb begin
        state_nx = state;
        vec_nx   = irq_vec;
        case (state)
            ST_IDLE: begin
                if (gie && win_valid) begin
                    state_nx = ST_REQ;
                    vec_nx   = win_idx;
                end
            end
            ST_REQ:  if (irq_ack) state_nx = ST_SVC;
            ST_SVC:  if (irq_ret) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state and core-facing outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            irq_vec <= '0;
            irq_req <= 1'b0;
        end else begin
            state   <= state_nx;
            irq_vec <= vec_nx;
            irq_req <= (state_nx == ST_REQ);
        end
    end

    // Source history and CPU-visible registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_prev <= '0;
            ipend    <= '0;
            imask    <= '0;
            iedge    <= '0;
            gie      <= 1'b0;
        end else begin
            src_prev <= src_in;
            ipend    <= ipend_nx;
            if (io_we && io_a == A_IMASK) imask <= io_di[N_IRQ-1:0];
            if (io_we && io_a == A_IEDGE) iedge <= io_di[N_IRQ-1:0];
            if (io_we && io_a == A_ICTRL) gie   <= io_di[BIT_GIE];
        end
    end

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[BIT_GIE]     = gie;
        ctrl_rd[BIT_REQ]     = (state == ST_REQ);
        ctrl_rd[BIT_SVC]     = (state == ST_SVC);
        ctrl_rd[VEC_W-1:0]   = irq_vec;
    end

    // Read mux shows current (pre-write) register contents
    always_comb begin
        io_do = '0;
        if (io_re) begin
            case (io_a)
                A_IPEND: io_do = 8'(ipend);
                A_IMASK: io_do = 8'(imask);
                A_IEDGE: io_do = 8'(iedge);
                default: io_do = ctrl_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
module tb_avr_irq_ctrl;

    localparam int unsigned N_IRQ = 8;
    localparam int unsigned VEC_W = 3;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_NORE = 2'd2;

    localparam logic [1:0] R_IPEND = 2'd0;
    localparam logic [1:0] R_IMASK = 2'd1;
    localparam logic [1:0] R_IEDGE = 2'd2;
    localparam logic [1:0] R_ICTRL = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [1:0] a;
        logic [7:0] di;
        logic [7:0] exp;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             io_re;
    logic             io_we;
    logic [1:0]       io_a;
    logic [7:0]       io_di;
    logic [7:0]       io_do;
    logic [N_IRQ-1:0] irq_src;
    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;
    logic             irq_ack;
    logic             irq_ret;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    avr_irq_ctrl #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_re   (io_re),
        .io_we   (io_we),
        .io_a    (io_a),
        .io_di   (io_di),
        .io_do   (io_do),
        .irq_src (irq_src),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack),
        .irq_ret (irq_ret)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        io_we = 1'b1;
        io_a  = a;
        io_di = d;
        tick();
        io_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
        io_re = 1'b1;
        io_a  = a;
        #1;
        chk(name, io_do, exp);
        io_re = 1'b0;
    endtask

    task automatic pulse_ack;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_ret;
        irq_ret = 1'b1;
        tick();
        irq_ret = 1'b0;
    endtask

    initial begin
        rst = 1'b0; io_re = 1'b0; io_we = 1'b0; io_a = '0; io_di = '0;
        irq_src = '0; irq_ack = 1'b0; irq_ret = 1'b0;
        tick();
        tick();
        chk("reset_req", 8'(irq_req), 8'h00);
        chk("reset_vec", 8'(irq_vec), 8'h00);
        rst = 1'b1;
        tick();

        // Register bus table
        tbl.push_back('{K_RD,   R_IPEND, 8'h00, 8'h00});
        tbl.push_back('{K_RD,   R_IMASK, 8'h00, 8'h00});
        tbl.push_back('{K_RD,   R_IEDGE, 8'h00, 8'h00});
        tbl.push_back('{K_RD,   R_ICTRL, 8'h00, 8'h00});
        tbl.push_back('{K_WR,   R_IMASK, 8'hA5, 8'h00});
        tbl.push_back('{K_RD,   R_IMASK, 8'h00, 8'hA5});
        tbl.push_back('{K_NORE, R_IMASK, 8'h00, 8'h00});
        tbl.push_back('{K_WR,   R_IEDGE, 8'h3C, 8'h00});
        tbl.push_back('{K_RD,   R_IEDGE, 8'h00, 8'h3C});
        tbl.push_back('{K_WR,   R_ICTRL, 8'hFF, 8'h00});
        tbl.push_back('{K_RD,   R_ICTRL, 8'h00, 8'h80});
        tbl.push_back('{K_WR,   R_ICTRL, 8'h00, 8'h00});
        tbl.push_back('{K_RD,   R_ICTRL, 8'h00, 8'h00});
        tbl.push_back('{K_WR,   R_IPEND, 8'hFF, 8'h00});
        tbl.push_back('{K_RD,   R_IPEND, 8'h00, 8'h00});
        tbl.push_back('{K_WR,   R_IMASK, 8'h00, 8'h00});
        tbl.push_back('{K_WR,   R_IEDGE, 8'h00, 8'h00});

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].kind)
                K_WR: wr(tbl[i].a, tbl[i].di);
                K_RD: rd($sformatf("tbl%0d_rd", i), tbl[i].a, tbl[i].exp);
                default: begin
                    io_re = 1'b0;
                    io_a  = tbl[i].a;
                    #1;
                    chk($sformatf("tbl%0d_nore", i), io_do, tbl[i].exp);
                end
            endcase
        end

        // Level source on bit 0
        wr(R_IEDGE, 8'h00);
        wr(R_IMASK, 8'h01);
        wr(R_ICTRL, 8'h80);
        irq_src = 8'h01;
        chk("lvl_req_t0", 8'(irq_req), 8'h00);
        tick();
        chk("lvl_req_t1", 8'(irq_req), 8'h00);
        tick();
        chk("lvl_req_t2", 8'(irq_req), 8'h01);
        chk("lvl_vec", 8'(irq_vec), 8'h00);
        rd("lvl_ictrl_req", R_ICTRL, 8'hC0);
        pulse_ack();
        chk("lvl_req_svc", 8'(irq_req), 8'h00);
        rd("lvl_ictrl_svc", R_ICTRL, 8'hA0);
        pulse_ret();
        chk("lvl_req_ret", 8'(irq_req), 8'h00);
        tick();
        chk("lvl_req_reassert", 8'(irq_req), 8'h01);
        irq_src = 8'h00;
        pulse_ack();
        pulse_ret();
        tick();
        chk("lvl_idle", 8'(irq_req), 8'h00);

        // Edge priority: sources 5 and 2 together
        wr(R_IEDGE, 8'hFF);
        wr(R_IMASK, 8'hFF);
        irq_src = 8'h24;
        tick();
        irq_src = 8'h00;
        tick();
        chk("edge_req1", 8'(irq_req), 8'h01);
        chk("edge_vec1", 8'(irq_vec), 8'h02);
        pulse_ack();
        rd("edge_ipend1", R_IPEND, 8'h20);
        pulse_ret();
        tick();
        chk("edge_req2", 8'(irq_req), 8'h01);
        chk("edge_vec2", 8'(irq_vec), 8'h05);
        pulse_ack();
        rd("edge_ipend2", R_IPEND, 8'h00);
        pulse_ret();

        // Mask / GIE gating on source 3
        wr(R_ICTRL, 8'h00);
        wr(R_IMASK, 8'h00);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        tick();
        rd("gate_ipend", R_IPEND, 8'h08);
        chk("gate_noreq", 8'(irq_req), 8'h00);
        wr(R_IMASK, 8'h08);
        wr(R_ICTRL, 8'h80);
        tick();
        chk("gate_req", 8'(irq_req), 8'h01);
        chk("gate_vec", 8'(irq_vec), 8'h03);
        irq_src = 8'h08;
        wr(R_IPEND, 8'h08);
        rd("gate_setwins", R_IPEND, 8'h08);
        wr(R_IPEND, 8'h08);
        rd("gate_w1c", R_IPEND, 8'h00);
        irq_src = 8'h00;
        pulse_ack();
        pulse_ret();

        // Handshake stability
        pulse_ack();
        chk("hs_ack_idle_req", 8'(irq_req), 8'h00);
        rd("hs_ack_idle_ctrl", R_ICTRL, 8'h83);
        wr(R_IEDGE, 8'h00);
        wr(R_IMASK, 8'h02);
        irq_src = 8'h02;
        tick();
        tick();
        chk("hs_req", 8'(irq_req), 8'h01);
        chk("hs_vec", 8'(irq_vec), 8'h01);
        pulse_ret();
        chk("hs_ret_in_req", 8'(irq_req), 8'h01);
        irq_src = 8'h00;
        wr(R_IMASK, 8'h00);
        tick();
        chk("hs_hold_req", 8'(irq_req), 8'h01);
        rd("hs_hold_ctrl", R_ICTRL, 8'hC1);
        pulse_ack();
        rd("hs_svc_ctrl", R_ICTRL, 8'hA1);
        wr(R_IEDGE, 8'h5A);
        wr(R_IMASK, 8'h33);
        rd("hs_iedge", R_IEDGE, 8'h5A);

        // Reset mid-SVC, asserted between edges
        rst = 1'b0;
        #1;
        chk("rst_req", 8'(irq_req), 8'h00);
        chk("rst_vec", 8'(irq_vec), 8'h00);
        rd("rst_ictrl", R_ICTRL, 8'h00);
        rd("rst_imask", R_IMASK, 8'h00);
        rd("rst_iedge", R_IEDGE, 8'h00);
        rd("rst_ipend", R_IPEND, 8'h00);
        tick();
        rst = 1'b1;
        tick();

        // Simultaneous read and write: read shows pre-write value
        io_we = 1'b1;
        io_re = 1'b1;
        io_a  = R_IMASK;
        io_di = 8'h0F;
        #1;
        chk("rw_pre", io_do, 8'h00);
        tick();
        io_we = 1'b0;
        io_re = 1'b0;
        rd("rw_post", R_IMASK, 8'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
